// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and the data width shared with data_memory.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package dmem_arbiter_pkg;

    localparam logic [1:0] ARB    = 2'd0;
    localparam logic [1:0] LOCK_A = 2'd1;
    localparam logic [1:0] LOCK_B = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int unsigned DMEM_DATA_WIDTH = `DATA_WIDTH;

endpackage

// File: rtl/dmem_arbiter_rr_grant2.sv
// Two-way round-robin pick: on a conflict the port opposite last_grant wins.
module rr_grant2
    import dmem_arbiter_pkg::*;
(
    input  logic valid_a_i,
    input  logic valid_b_i,
    input  logic last_grant_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    always_comb begin
        grant_a_o = valid_a_i & (~valid_b_i | (last_grant_i == PORT_B));
        grant_b_o = valid_b_i & ~grant_a_o;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data_memory between port A and port B.
// Optional conflict counter enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_valid,
    input  logic                  i_a_we,
    input  logic                  i_a_lock,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    output logic                  o_a_ready,
    output logic                  o_a_rvalid,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_valid,
    input  logic                  i_b_we,
    input  logic                  i_b_lock,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    output logic                  o_b_ready,
    output logic                  o_b_rvalid,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]           o_conflict_cnt
`endif
);

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

    logic rr_grant_a, rr_grant_b;
    logic grant_a, grant_b;
    logic acc_a, acc_b;

    rr_grant2 u_rr (
        .valid_a_i    (i_a_valid),
        .valid_b_i    (i_b_valid),
        .last_grant_i (last_grant_q),
        .grant_a_o    (rr_grant_a),
        .grant_b_o    (rr_grant_b)
    );

    // While locked only the owner can be granted, and only when it is valid.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state_q)
            ARB: begin
                grant_a = rr_grant_a;
                grant_b = rr_grant_b;
            end
            LOCK_A:  grant_a = i_a_valid;
            LOCK_B:  grant_b = i_b_valid;
            default: ;
        endcase
    end

    assign o_a_ready = grant_a;
    assign o_b_ready = grant_b;
    assign acc_a     = i_a_valid & grant_a;
    assign acc_b     = i_b_valid & grant_b;

    assign o_mem_addr  = grant_b ? i_b_addr  : i_a_addr;
    assign o_mem_wdata = grant_b ? i_b_wdata : i_a_wdata;
    assign o_mem_we    = ~i_rst & ((acc_a & i_a_we) | (acc_b & i_b_we));

    // A locked owner that is idle leaves the lock exactly when it drops i_x_lock,
    // which also covers the final unlocked access since valid implies accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (acc_a && i_a_lock)
                    state_d = LOCK_A;
                else if (acc_b && i_b_lock)
                    state_d = LOCK_B;
            end
            LOCK_A:  if (!i_a_lock) state_d = ARB;
            LOCK_B:  if (!i_b_lock) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (acc_a)
            last_grant_d = PORT_A;
        else if (acc_b)
            last_grant_d = PORT_B;
    end

    always_comb begin
        a_rvalid_d = acc_a & ~i_a_we;
        b_rvalid_d = acc_b & ~i_b_we;
        a_rdata_d  = a_rvalid_d ? i_mem_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? i_mem_rdata : b_rdata_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ARB;
            last_grant_q <= PORT_B;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign o_a_rvalid = a_rvalid_q;
    assign o_b_rvalid = b_rvalid_q;
    assign o_a_rdata  = a_rdata_q;
    assign o_b_rdata  = b_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (i_a_valid && i_b_valid && (conflict_cnt_q != 16'hFFFF))
            conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            conflict_cnt_q <= '0;
        else
            conflict_cnt_q <= conflict_cnt_d;
    end

    assign o_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, a_we, a_lock;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic        a_ready, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_valid, b_we, b_lock;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_ready, b_rvalid;
    logic [31:0] b_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_a_valid   (a_valid),
        .i_a_we      (a_we),
        .i_a_lock    (a_lock),
        .i_a_addr    (a_addr),
        .i_a_wdata   (a_wdata),
        .o_a_ready   (a_ready),
        .o_a_rvalid  (a_rvalid),
        .o_a_rdata   (a_rdata),
        .i_b_valid   (b_valid),
        .i_b_we      (b_we),
        .i_b_lock    (b_lock),
        .i_b_addr    (b_addr),
        .i_b_wdata   (b_wdata),
        .o_b_ready   (b_ready),
        .o_b_rvalid  (b_rvalid),
        .o_b_rdata   (b_rdata),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .o_conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic        rst;
        logic        av, awe, alk;
        logic [9:0]  aad;
        logic [31:0] awd;
        logic        bv, bwe, blk;
        logic [9:0]  bad;
        logic [31:0] bwd;
        logic        ear, ebr, ewe;
        logic [9:0]  ead;
        logic        earv, ebrv;
        logic [31:0] eard, ebrd;
    } vec_t;

    vec_t vecs [0:21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        a_valid = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic pulse_reset();
        drive_idle();
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        string t;
        if (v.rst) pulse_reset();
        a_valid = v.av; a_we = v.awe; a_lock = v.alk; a_addr = v.aad; a_wdata = v.awd;
        b_valid = v.bv; b_we = v.bwe; b_lock = v.blk; b_addr = v.bad; b_wdata = v.bwd;
        #1;
        t = $sformatf("v%0d", idx);
        chk({t, " a_ready"}, 32'(a_ready), 32'(v.ear));
        chk({t, " b_ready"}, 32'(b_ready), 32'(v.ebr));
        chk({t, " mem_we"},  32'(mem_we),  32'(v.ewe));
        chk({t, " mem_addr"}, 32'(mem_addr), 32'(v.ead));
        @(posedge clk);
        #1;
        chk({t, " a_rvalid"}, 32'(a_rvalid), 32'(v.earv));
        chk({t, " b_rvalid"}, 32'(b_rvalid), 32'(v.ebrv));
        chk({t, " a_rdata"}, a_rdata, v.eard);
        chk({t, " b_rdata"}, b_rdata, v.ebrd);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);

        //         rst   av   awe  alk  aad     awd            bv   bwe  blk  bad     bwd        ear  ebr  ewe  ead     earv ebrv eard           ebrd
        vecs[0]  = '{1'b0, 1'b1,1'b1,1'b0,10'h010,32'hDEADBEEF, 1'b0,1'b0,1'b0,10'h000,32'h0, 1'b1,1'b0,1'b1,10'h010, 1'b0,1'b0,32'h0,         32'h0};
        vecs[1]  = '{1'b0, 1'b1,1'b0,1'b0,10'h010,32'h0,        1'b0,1'b0,1'b0,10'h000,32'h0, 1'b1,1'b0,1'b0,10'h010, 1'b1,1'b0,32'hDEADBEEF,  32'h0};
        vecs[2]  = '{1'b0, 1'b0,1'b0,1'b0,10'h3FC,32'h0,        1'b0,1'b0,1'b0,10'h100,32'h0, 1'b0,1'b0,1'b0,10'h3FC, 1'b0,1'b0,32'hDEADBEEF,  32'h0};
        vecs[3]  = '{1'b1, 1'b1,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b1,1'b0,1'b0,10'h000, 1'b1,1'b0,32'hA5000000,  32'h0};
        vecs[4]  = '{1'b0, 1'b1,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b0,1'b1,1'b0,10'h004, 1'b0,1'b1,32'hA5000000,  32'hA5000004};
        vecs[5]  = '{1'b0, 1'b1,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b1,1'b0,1'b0,10'h000, 1'b1,1'b0,32'hA5000000,  32'hA5000004};
        vecs[6]  = '{1'b0, 1'b1,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b0,1'b1,1'b0,10'h004, 1'b0,1'b1,32'hA5000000,  32'hA5000004};
        vecs[7]  = '{1'b0, 1'b0,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b1,1'b0,10'h020,32'h55,1'b0,1'b1,1'b1,10'h020, 1'b0,1'b0,32'hA5000000,  32'hA5000004};
        vecs[8]  = '{1'b0, 1'b0,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h020,32'h0, 1'b0,1'b1,1'b0,10'h020, 1'b0,1'b1,32'hA5000000,  32'h55};
        vecs[9]  = '{1'b0, 1'b1,1'b0,1'b1,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b1,1'b0,1'b0,10'h000, 1'b1,1'b0,32'hA5000000,  32'h55};
        vecs[10] = '{1'b0, 1'b1,1'b1,1'b1,10'h008,32'h111,      1'b1,1'b0,1'b0,10'h004,32'h0, 1'b1,1'b0,1'b1,10'h008, 1'b0,1'b0,32'hA5000000,  32'h55};
        vecs[11] = '{1'b0, 1'b1,1'b0,1'b1,10'h008,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b1,1'b0,1'b0,10'h008, 1'b1,1'b0,32'h111,       32'h55};
        vecs[12] = '{1'b0, 1'b1,1'b0,1'b0,10'h010,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b1,1'b0,1'b0,10'h010, 1'b1,1'b0,32'hDEADBEEF,  32'h55};
        vecs[13] = '{1'b0, 1'b1,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b0,1'b1,1'b0,10'h004, 1'b0,1'b1,32'hDEADBEEF,  32'hA5000004};
        vecs[14] = '{1'b0, 1'b1,1'b0,1'b1,10'h000,32'h0,        1'b0,1'b0,1'b0,10'h004,32'h0, 1'b1,1'b0,1'b0,10'h000, 1'b1,1'b0,32'hA5000000,  32'hA5000004};
        vecs[15] = '{1'b0, 1'b0,1'b0,1'b1,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b0,1'b0,1'b0,10'h000, 1'b0,1'b0,32'hA5000000,  32'hA5000004};
        vecs[16] = '{1'b0, 1'b0,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b0,1'b0,1'b0,10'h000, 1'b0,1'b0,32'hA5000000,  32'hA5000004};
        vecs[17] = '{1'b0, 1'b0,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h004,32'h0, 1'b0,1'b1,1'b0,10'h004, 1'b0,1'b1,32'hA5000000,  32'hA5000004};
        vecs[18] = '{1'b0, 1'b0,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b1,10'h020,32'h0, 1'b0,1'b1,1'b0,10'h020, 1'b0,1'b1,32'hA5000000,  32'h55};
        vecs[19] = '{1'b0, 1'b1,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b1,1'b0,10'h024,32'h77,1'b0,1'b1,1'b1,10'h024, 1'b0,1'b0,32'hA5000000,  32'h55};
        vecs[20] = '{1'b0, 1'b1,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h024,32'h0, 1'b1,1'b0,1'b0,10'h000, 1'b1,1'b0,32'hA5000000,  32'h55};
        vecs[21] = '{1'b0, 1'b0,1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,1'b0,10'h024,32'h0, 1'b0,1'b1,1'b0,10'h024, 1'b0,1'b1,32'hA5000000,  32'h77};

        // Reset state, with a write presented that must not reach memory.
        drive_idle();
        rst = 1;
        a_valid = 1; a_we = 1; a_addr = 10'h040; a_wdata = 32'h1234_5678;
        #1;
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst a_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst b_rvalid", 32'(b_rvalid), 32'h0);
        chk("rst a_rdata", a_rdata, 32'h0);
        chk("rst b_rdata", b_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 0;
        drive_idle();
        chk("rst write dropped", mem[10'h040], 32'hA5000040);

        for (int i = 0; i < 22; i++) apply(i, vecs[i]);

        // Reset lands between acceptance of a read and its response edge.
        a_valid = 1; a_we = 0; a_addr = 10'h000;
        #1 chk("midrst a_ready", 32'(a_ready), 32'h1);
        rst = 1;
        #1 chk("midrst a_rvalid async", 32'(a_rvalid), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst a_rvalid", 32'(a_rvalid), 32'h0);
        chk("midrst a_rdata", a_rdata, 32'h0);
        a_we = 1; a_addr = 10'h030; a_wdata = 32'h0BAD;
        #1 chk("midrst mem_we", 32'(mem_we), 32'h0);
        @(posedge clk);
        #1 rst = 0;
        a_we = 0; a_addr = 10'h030;
        b_valid = 1; b_addr = 10'h004;
        #1;
        chk("post-rst a_ready", 32'(a_ready), 32'h1);
        chk("post-rst b_ready", 32'(b_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("post-rst a_rvalid", 32'(a_rvalid), 32'h1);
        chk("post-rst a_rdata", a_rdata, 32'hA5000030);
        chk("post-rst b_rvalid", 32'(b_rvalid), 32'h0);

        // A lock held across reset must be dropped.
        drive_idle();
        a_valid = 1; a_lock = 1; a_addr = 10'h000;
        #1 chk("lockrst a_ready", 32'(a_ready), 32'h1);
        @(posedge clk);
        #1 pulse_reset();
        a_lock = 1; b_valid = 1; b_addr = 10'h004;
        #1 chk("lockrst b_ready", 32'(b_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("lockrst b_rvalid", 32'(b_rvalid), 32'h1);
        chk("lockrst b_rdata", b_rdata, 32'hA5000004);

`ifdef DMEM_ARB_STATS_EN
        pulse_reset();
        chk("stats reset", 32'(conflict_cnt), 32'h0);
        a_valid = 1; b_valid = 1; a_addr = 10'h000; b_addr = 10'h004;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        drive_idle();
        chk("stats five", 32'(conflict_cnt), 32'h5);
        @(posedge clk);
        #1 chk("stats idle hold", 32'(conflict_cnt), 32'h5);
        rst = 1;
        #1 chk("stats cleared", 32'(conflict_cnt), 32'h0);
        @(posedge clk);
        #1 rst = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data_memory between two requesters: port A (core load/store unit) and port B (debug/DMA loader).
- Arbitrates round-robin, or fixed-priority when locked, over a valid/ready request handshake.
- Drives the memory's write-enable, address and data.
- Returns read data one cycle after acceptance, registered, with a response-valid strobe and the requester identified.

Parameters:
- DATA_WIDTH, 32, data word width; must match the `DATA_WIDTH` define used by data_memory.
- ADDR_WIDTH, 10, byte-address width; equals $clog2(MEM_SIZE) for MEM_SIZE 1024.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_a_valid  in  1  port A request valid.
- i_a_we  in  1  port A write (1) or read (0).
- i_a_lock  in  1  port A keeps the grant after this access.
- i_a_addr  in  ADDR_WIDTH  port A address.
- i_a_wdata  in  DATA_WIDTH  port A write data.
- o_a_ready  out  1  port A request accepted this cycle.
- o_a_rvalid  out  1  port A read data valid.
- o_a_rdata  out  DATA_WIDTH  port A read data.
- i_b_* / o_b_*: identical set for port B.
- o_mem_we  out  1  to data_memory i_we.
- o_mem_addr  out  ADDR_WIDTH  to data_memory i_addr.
- o_mem_wdata  out  DATA_WIDTH  to data_memory i_data.
- i_mem_rdata  in  DATA_WIDTH  from data_memory o_data; combinational read.

Behaviour:
- One clock domain (i_clk). Reset is asynchronous, active-high (i_rst).
- Reset values:
  - o_a_rvalid = o_b_rvalid = 0.
  - o_a_rdata = o_b_rdata = 0.
  - last_grant = B, so A wins the first conflict.
  - FSM = ARB.
  - o_mem_we = 0 while i_rst is high.
- FSM states: ARB, LOCK_A, LOCK_B.
  - ARB:
    - Only one valid → grant it.
    - Both valid → grant the side opposite last_grant.
    - last_grant updates on every acceptance.
  - ARB → LOCK_x: on acceptance from port x with i_x_lock = 1.
  - LOCK_x:
    - Only port x can be granted; the other port's ready stays 0 even if valid.
    - Exit to ARB on an acceptance from x with i_x_lock = 0.
    - Exit to ARB if i_x_valid = 0 and i_x_lock = 0 in the same cycle (lock abandoned).
    - Stay if i_x_valid = 0 and i_x_lock = 1.
- Grant is combinational within the cycle.
  - o_x_ready = grant_x; accepted = i_x_valid & o_x_ready.
  - ready is never asserted to a port that is not valid.
- Memory drive:
  - o_mem_addr / o_mem_wdata come from the granted port; with no grant they hold port A's values.
  - o_mem_we = accepted & i_x_we of the granted port.
  - The write commits at that rising edge.
- Read response:
  - On an accepted read, i_mem_rdata is registered into o_x_rdata at the edge.
  - o_x_rvalid = 1 for exactly one cycle, in the cycle after acceptance.
  - o_x_rdata holds its value until the next read response to that port.
  - Writes produce no rvalid.
- Throughput: one access per cycle total. Back-to-back reads from the same port give rvalid on consecutive cycles.
- Reset mid-operation:
  - Lock is dropped and pending rvalid is cleared.
  - Any write presented in the reset cycle is not performed (o_mem_we forced 0).
- Address is passed through unchanged. No alignment checking.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output o_conflict_cnt [15:0], reset 0.
  - Increments on every cycle where both i_a_valid and i_b_valid are 1, including while locked.
  - Saturates at 16'hFFFF.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: ARB = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2.
  - Port index constants: PORT_A = 1'b0, PORT_B = 1'b1.
  - The DATA_WIDTH define.
- One sub-module, rr_grant2: combinational 2-way round-robin pick given valid and last_grant.

Test Plan:
- Single requester: A writes 32'hDEADBEEF to addr 10'h010; A reads 10'h010 → o_a_ready = 1 both cycles; o_a_rvalid = 1 one cycle after the read; o_a_rdata = 32'hDEADBEEF.
- Conflict: A and B both valid reading 10'h000 / 10'h004 for 4 cycles after reset → grants A, B, A, B; rvalid alternates A/B one cycle later.
- Lock: A accepted with lock = 1; B valid throughout; A issues 3 more accesses, the last with lock = 0 → o_b_ready = 0 for the 4 A cycles, then B granted next cycle.
- Idle/abandon lock: A locks, then drops valid and lock together → FSM returns to ARB; pending B granted the following cycle.
- Reset mid-read: read accepted, i_rst asserted before the next edge → o_a_rvalid stays 0; o_mem_we = 0 during reset; first post-reset conflict goes to A.
- With DMEM_ARB_STATS_EN: 5 cycles of both-valid → o_conflict_cnt = 5; after i_rst → 0.
